// File: rtl/rv32i_types.sv
// rv32i_types: shared front-end types and sizing constants.
package rv32i_types;
    localparam int INST_Q_DEPTH = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_curr;
        logic [31:0] pc_next;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
    } instruction_info_reg_t;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular FIFO between decode and rename/dispatch.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module inst_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = INST_Q_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq_valid,
    input  instruction_info_reg_t enq_data,
    output logic                  enq_ready,
    input  logic                  deq_ready,
    output logic                  deq_valid,
    output instruction_info_reg_t deq_data,
    input  logic                  flush,
    output logic [PTR_W:0]        count
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("inst_queue: DEPTH must be a power of two and at least 2");
    end

    instruction_info_reg_t mem [DEPTH];
    logic [PTR_W:0] head, tail;
    logic full, empty, do_enq, do_deq;

    always_comb begin
        empty     = head == tail;
        full      = (head[PTR_W-1:0] == tail[PTR_W-1:0]) && (head[PTR_W] != tail[PTR_W]);
        enq_ready = !full;
        deq_valid = !empty;
        count     = tail - head;
        deq_data  = mem[head[PTR_W-1:0]];
        do_enq    = enq_valid && !full && !flush;
        do_deq    = deq_ready && !empty && !flush;
    end

    // Full never enqueues and empty never dequeues, so the two writes below never share an index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
        end else begin
            if (do_enq) begin
                mem[tail[PTR_W-1:0]] <= enq_data;
                tail <= tail + 1'b1;
            end
            if (do_deq) begin
                mem[head[PTR_W-1:0]].valid <= 1'b0;
                head <= head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) assert (!$isunknown({enq_valid, deq_ready, flush}));
    end
endmodule
